// File: rtl/etaiim_pkg.sv
// Shared ETAIIM adder defaults and a behavioural reference sum.
// The reference walks segments LSB-first using the same carry rule as the hardware.
package etaiim_pkg;

  localparam int WIDTH     = 32;
  localparam int SEG_W     = 4;
  localparam int NUM_SEG   = 8;
  localparam int CHAIN_SEG = 3;
  localparam int PRED_LAST = NUM_SEG - CHAIN_SEG;

  function automatic logic [WIDTH:0] etaiim_ref(input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b);
    logic [WIDTH:0]   res;
    logic [SEG_W:0]   gen;
    logic [SEG_W:0]   tot;
    logic [SEG_W-1:0] sa;
    logic [SEG_W-1:0] sb;
    logic             cin;
    logic             g_prev;
    logic             p_prev;
    res    = '0;
    cin    = 1'b0;
    g_prev = 1'b0;
    p_prev = 1'b0;
    for (int i = 0; i < NUM_SEG; i++) begin
      sa = a[i*SEG_W +: SEG_W];
      sb = b[i*SEG_W +: SEG_W];
      // Low segments only see a predicted carry; the top ones form an exact chain.
      if (i == 0)              cin = 1'b0;
      else if (i <= PRED_LAST) cin = g_prev;
      else                     cin = g_prev | (p_prev & cin);
      gen = {1'b0, sa} + {1'b0, sb};
      tot = gen + {{SEG_W{1'b0}}, cin};
      res[i*SEG_W +: SEG_W] = tot[SEG_W-1:0];
      if (i == NUM_SEG - 1) res[WIDTH] = tot[SEG_W];
      g_prev = gen[SEG_W];
      p_prev = &(sa ^ sb);
    end
    return res;
  endfunction

endpackage

// File: rtl/etaiim_seg.sv
// One combinational ETAIIM segment: local sum plus generate/propagate
// signals computed without the incoming carry.
module etaiim_seg #(
  parameter int SEG_W = 4
) (
  input  logic [SEG_W-1:0] a,
  input  logic [SEG_W-1:0] b,
  input  logic             cin,
  output logic [SEG_W-1:0] s,
  output logic             g,
  output logic             p,
  output logic             cout
);

  logic [SEG_W:0] gen_sum;
  logic [SEG_W:0] full_sum;

  assign gen_sum  = {1'b0, a} + {1'b0, b};
  assign full_sum = gen_sum + {{SEG_W{1'b0}}, cin};

  assign s    = full_sum[SEG_W-1:0];
  assign cout = full_sum[SEG_W];
  assign g    = gen_sum[SEG_W];
  assign p    = &(a ^ b);

endmodule

// File: rtl/etaiim32_adder.sv
// Registered 32-bit ETAIIM approximate adder: predicted carries in the low
// segments, exact chained carry across the top CHAIN_SEG segments.
module etaiim32_adder #(
  parameter int WIDTH     = etaiim_pkg::WIDTH,
  parameter int SEG_W     = etaiim_pkg::SEG_W,
  parameter int NUM_SEG   = etaiim_pkg::NUM_SEG,
  parameter int CHAIN_SEG = etaiim_pkg::CHAIN_SEG
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  output logic [WIDTH:0]   Sum
);

  localparam int PRED_LAST = NUM_SEG - CHAIN_SEG;

  if (WIDTH != SEG_W * NUM_SEG) begin : g_bad_width
    $error("etaiim32_adder: WIDTH must equal SEG_W*NUM_SEG");
  end
  if (CHAIN_SEG < 1 || CHAIN_SEG > NUM_SEG - 1) begin : g_bad_chain
    $error("etaiim32_adder: CHAIN_SEG must be within 1..NUM_SEG-1");
  end

  logic [NUM_SEG-1:0] seg_g;
  logic [NUM_SEG-1:0] seg_p;
  logic [NUM_SEG-1:0] seg_co;
  logic [NUM_SEG-1:0] seg_cin;
  logic [WIDTH-1:0]   seg_s;
  logic [WIDTH:0]     sum_d;
  logic [WIDTH:0]     sum_q;
  logic               valid_q;
  logic               seg_unused;

  for (genvar i = 0; i < NUM_SEG; i++) begin : g_seg
    etaiim_seg #(.SEG_W(SEG_W)) u_seg (
      .a    (A[i*SEG_W +: SEG_W]),
      .b    (B[i*SEG_W +: SEG_W]),
      .cin  (seg_cin[i]),
      .s    (seg_s[i*SEG_W +: SEG_W]),
      .g    (seg_g[i]),
      .p    (seg_p[i]),
      .cout (seg_co[i])
    );
  end

  // Segments 1..PRED_LAST take the neighbour's generate only; above that the carry ripples exactly.
  always_comb begin
    seg_cin = '0;
    for (int i = 1; i < NUM_SEG; i++) begin
      if (i <= PRED_LAST) seg_cin[i] = seg_g[i-1];
      else                seg_cin[i] = seg_g[i-1] | (seg_p[i-1] & seg_cin[i-1]);
    end
  end

  assign sum_d = {seg_co[NUM_SEG-1], seg_s};

  // Intra-segment carry-outs and the top segment's g/p are not part of the carry network.
  assign seg_unused = ^{seg_co[NUM_SEG-2:0], seg_g[NUM_SEG-1], seg_p[NUM_SEG-1],
                        seg_p[PRED_LAST-1:0]};

  always_ff @(posedge Clk) begin
    if (Rst) begin
      sum_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      sum_q   <= sum_d;
      valid_q <= in_valid;
    end
  end

  assign Sum       = sum_q;
  assign out_valid = valid_q;

endmodule

// File: tb/tb_etaiim32_adder.sv
// Bench for etaiim32_adder: fixed vectors, reset/idle sequences, then random
// pairs scored against the package reference through an expectation queue.
module tb_etaiim32_adder;
  import etaiim_pkg::*;

  logic        Clk;
  logic        Rst;
  logic        in_valid;
  logic [31:0] A;
  logic [31:0] B;
  logic        out_valid;
  logic [32:0] Sum;

  int total;
  int bad;
  logic [32:0] exp_q[$];

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [32:0] exp;
  } vec_t;

  vec_t vecs[6];

  etaiim32_adder dut (
    .Clk       (Clk),
    .Rst       (Rst),
    .in_valid  (in_valid),
    .A         (A),
    .B         (B),
    .out_valid (out_valid),
    .Sum       (Sum)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string name, input logic [32:0] act, input logic [32:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock: apply inputs, push the expectation if a result is due, check after the edge.
  task automatic step(input logic [31:0] a, input logic [31:0] b, input logic v,
                      input logic rst, input logic [32:0] exp, input string name);
    logic exp_v;
    logic [32:0] e;
    A        = a;
    B        = b;
    in_valid = v;
    Rst      = rst;
    exp_v    = v && !rst;
    if (exp_v) exp_q.push_back(exp);
    @(posedge Clk);
    #1;
    chk({name, "_valid"}, {32'b0, out_valid}, {32'b0, exp_v});
    if (out_valid) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL %s_underflow: got result %h with no expectation queued", name, Sum);
      end else begin
        e = exp_q.pop_front();
        chk(name, Sum, e);
      end
    end else begin
      if (rst) chk({name, "_rst_sum"}, Sum, 33'h0);
      else     chk({name, "_idle_sum"}, Sum, exp);
      exp_q.delete();
    end
  endtask

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    logic [32:0] rexp;
    logic [32:0] exact;
    longint      err;
    longint      max_err;
    int          n_inexact;

    total     = 0;
    bad       = 0;
    max_err   = 0;
    n_inexact = 0;

    vecs[0] = '{32'h0000_0001, 32'h0000_0002, 33'h0_0000_0003};
    vecs[1] = '{32'h0000_000F, 32'h0000_0001, 33'h0_0000_0010};
    vecs[2] = '{32'h0000_00FF, 32'h0000_0001, 33'h0_0000_0000};
    vecs[3] = '{32'h0FF0_0000, 32'h0010_0000, 33'h0_1000_0000};
    vecs[4] = '{32'hFFFF_FFFF, 32'h0000_0001, 33'h0_FFFF_FF00};
    vecs[5] = '{32'hF000_0000, 32'h1000_0000, 33'h1_0000_0000};

    A = '0; B = '0; in_valid = 1'b0; Rst = 1'b1;

    step(32'h1234_5678, 32'h1111_1111, 1'b1, 1'b1, 33'h0, "reset0");
    step(32'h1234_5678, 32'h1111_1111, 1'b1, 1'b1, 33'h0, "reset1");
    step(32'h0000_0005, 32'h0000_0006, 1'b1, 1'b0, 33'h0_0000_000B, "release");

    for (int i = 0; i < 6; i++) begin
      chk($sformatf("ref_fn%0d", i), etaiim_ref(vecs[i].a, vecs[i].b), vecs[i].exp);
      step(vecs[i].a, vecs[i].b, 1'b1, 1'b0, vecs[i].exp, $sformatf("vec%0d", i));
    end

    // Idle cycle: result still computed, just not qualified.
    step(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 33'h0_0000_0000, "idle");

    // Reset mid-stream discards the in-flight pair, then streaming resumes.
    step(32'h0000_000F, 32'h0000_0001, 1'b1, 1'b0, 33'h0_0000_0010, "pre_rst");
    step(32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 1'b1, 33'h0, "mid_rst");
    step(32'h0FF0_0000, 32'h0010_0000, 1'b1, 1'b0, 33'h0_1000_0000, "post_rst");

    for (int i = 0; i < 10000; i++) begin
      ra = $urandom;
      case (i % 3)
        0:       rb = $urandom;
        1:       rb = ~ra ^ (32'h1 << $urandom_range(0, 31));
        default: rb = $urandom & 32'h0000_FFFF;
      endcase
      rexp = etaiim_ref(ra, rb);
      step(ra, rb, (i % 8) != 7, 1'b0, rexp, "rand");
      exact = {1'b0, ra} + {1'b0, rb};
      err   = longint'(exact) - longint'(rexp);
      if (err < 0) err = -err;
      if (err != 0) n_inexact++;
      if (err > max_err) max_err = err;
    end
    $display("random error log: inexact=%0d max_abs_err=%0d", n_inexact, max_err);

    step(32'h0, 32'h0, 1'b0, 1'b0, 33'h0, "drain");
    chk("sb_empty", 33'(exp_q.size()), 33'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
